// File: rtl/alu_result_deserializer.sv
// Serial receiver for ALU result frames: oversampled 11-bit frame recovery plus
// packet assembly (4 data bytes + result control, or a lone error control).
module alu_result_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        res_valid,
  output logic [31:0] data_out,
  output logic [3:0]  flags_out,
  output logic [2:0]  crc_out,
  output logic        crc_err,
  output logic        err_valid,
  output logic [5:0]  err_flags_out,
  output logic        parity_err,
  output logic        frame_err,
  output logic        proto_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, TYPE, PAYLOAD, STOP} state_t;

  state_t      state, state_n;
  logic [1:0]  sync_ff;
  logic        s, s_prev;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic        type_bit;
  logic [7:0]  shreg;
  logic        tick;
  logic        stop_ok, stop_bad;
  logic [2:0]  idx;
  logic [31:0] data_buf;

  // x^3+x+1, MSB first, seed 000
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign s = sync_ff[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b11;
      s_prev  <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[0], sin};
      s_prev  <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    tick    = 1'b0;
    case (state)
      IDLE:    if (s_prev && !s) state_n = START;
      START:   if (cnt == HALF) begin
                 tick    = 1'b1;
                 state_n = s ? IDLE : TYPE;
               end
      TYPE:    if (cnt == FULL) begin
                 tick    = 1'b1;
                 state_n = PAYLOAD;
               end
      PAYLOAD: if (cnt == FULL) begin
                 tick = 1'b1;
                 if (bit_idx == 3'd7) state_n = STOP;
               end
      STOP:    if (cnt == FULL) begin
                 tick    = 1'b1;
                 state_n = IDLE;
               end
      default: state_n = IDLE;
    endcase
  end

  assign stop_ok  = (state == STOP) && tick && s;
  assign stop_bad = (state == STOP) && tick && !s;

  // Counter restarts on every sample so the next sample lands one bit later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      type_bit <= 1'b0;
      shreg    <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == IDLE) bit_idx <= '0;
      if (tick && state == TYPE) type_bit <= s;
      if (tick && state == PAYLOAD) begin
        shreg   <= {shreg[6:0], s};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Packet assembly; data_out only moves when a complete packet is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      data_buf      <= '0;
      res_valid     <= 1'b0;
      err_valid     <= 1'b0;
      frame_err     <= 1'b0;
      proto_err     <= 1'b0;
      data_out      <= '0;
      flags_out     <= '0;
      crc_out       <= '0;
      crc_err       <= 1'b0;
      err_flags_out <= '0;
      parity_err    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err_valid <= 1'b0;
      frame_err <= 1'b0;
      proto_err <= 1'b0;
      if (stop_bad) begin
        frame_err <= 1'b1;
        idx       <= '0;
      end else if (stop_ok) begin
        if (!type_bit) begin
          if (idx < 3'd4) begin
            case (idx[1:0])
              2'd0: data_buf[31:24] <= shreg;
              2'd1: data_buf[23:16] <= shreg;
              2'd2: data_buf[15:8]  <= shreg;
              default: data_buf[7:0] <= shreg;
            endcase
            idx <= idx + 3'd1;
          end else begin
            proto_err <= 1'b1;
            idx       <= '0;
          end
        end else if (!shreg[7]) begin
          if (idx == 3'd4) begin
            data_out  <= data_buf;
            flags_out <= shreg[6:3];
            crc_out   <= shreg[2:0];
            crc_err   <= crc3({data_buf, 1'b0, shreg[6:3]}) != shreg[2:0];
            res_valid <= 1'b1;
          end else begin
            proto_err <= 1'b1;
          end
          idx <= '0;
        end else begin
          if (idx == 3'd0) begin
            err_flags_out <= shreg[6:1];
            parity_err    <= ~^shreg[6:0];
            err_valid     <= 1'b1;
          end else begin
            proto_err <= 1'b1;
          end
          idx <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_deserializer.sv
// Scoreboard bench for alu_result_deserializer: expected packets are queued as
// frames are driven and popped when the receiver pulses.
module tb_alu_result_deserializer;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        res_valid, crc_err, err_valid, parity_err, frame_err, proto_err;
  logic [31:0] data_out;
  logic [3:0]  flags_out;
  logic [2:0]  crc_out;
  logic [5:0]  err_flags_out;

  typedef struct {
    int          kind; // 0 result, 1 error, 2 frame_err, 3 proto_err
    logic [31:0] data;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_err;
    logic [5:0]  eflags;
    logic        par_err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  alu_result_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .sin(sin),
    .res_valid(res_valid), .data_out(data_out), .flags_out(flags_out),
    .crc_out(crc_out), .crc_err(crc_err),
    .err_valid(err_valid), .err_flags_out(err_flags_out), .parity_err(parity_err),
    .frame_err(frame_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC by polynomial long division of {stream, 000} by 1011.
  function automatic logic [2:0] crc_ref(input logic [31:0] d, input logic [3:0] f);
    logic [39:0] v;
    v = {d, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
    return v[2:0];
  endfunction

  function automatic exp_t mk(input int kind);
    exp_t e;
    e.kind = kind; e.data = '0; e.flags = '0; e.crc = '0;
    e.crc_err = 1'b0; e.eflags = '0; e.par_err = 1'b0;
    return e;
  endfunction

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] p, input logic stp);
    logic [10:0] bits;
    bits = {1'b0, t, p, stp};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_result(input logic [31:0] d, input logic [3:0] f, input logic [2:0] c);
    exp_t e;
    e = mk(0);
    e.data = d; e.flags = f; e.crc = c; e.crc_err = (c != crc_ref(d, f));
    for (int b = 3; b >= 0; b--) send_frame(1'b0, d[8*b +: 8], 1'b1);
    q.push_back(e);
    send_frame(1'b1, {1'b0, f, c}, 1'b1);
  endtask

  task automatic send_error(input logic [5:0] ef, input logic par);
    exp_t e;
    e = mk(1);
    e.eflags = ef;
    e.par_err = ($countones({ef, par}) % 2) == 0;
    q.push_back(e);
    send_frame(1'b1, {1'b1, ef, par}, 1'b1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int   pc, kind;
    exp_t e;
    if (!rst) begin
      pc = int'(res_valid) + int'(err_valid) + int'(frame_err) + int'(proto_err);
      if (pc > 1) chk("pulse_onehot", 64'(pc), 64'd1);
      if (pc != 0) begin
        kind = res_valid ? 0 : err_valid ? 1 : frame_err ? 2 : 3;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 64'(kind), 64'hdead);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", 64'(kind), 64'(e.kind));
          if (e.kind == 0) begin
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("flags_out", 64'(flags_out), 64'(e.flags));
            chk("crc_out", 64'(crc_out), 64'(e.crc));
            chk("crc_err", 64'(crc_err), 64'(e.crc_err));
          end else if (e.kind == 1) begin
            chk("err_flags_out", 64'(err_flags_out), 64'(e.eflags));
            chk("parity_err", 64'(parity_err), 64'(e.par_err));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_outputs", {res_valid, err_valid, frame_err, proto_err, crc_err, parity_err,
                        flags_out, crc_out, err_flags_out}, 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    rst = 1'b0;
    idle(200);
    chk("idle_no_pulse", 64'(q.size()), 64'd0);

    send_result(32'h0, 4'h0, 3'b000);
    send_result(32'h0, 4'h0, 3'b001);
    send_result(32'h12345678, 4'b1010, crc_ref(32'h12345678, 4'b1010));
    send_result(32'hdeadbeef, 4'b0111, crc_ref(32'hdeadbeef, 4'b0111) ^ 3'b100);
    idle(CPB);

    send_error(6'b100100, 1'b1);
    send_error(6'b100100, 1'b0);
    send_error(6'b111111, 1'b1);
    idle(CPB);

    // Stop bit 0 after two data frames must also clear the packet index.
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b1);
    q.push_back(mk(2));
    send_frame(1'b0, 8'hCC, 1'b0);
    idle(2 * CPB);
    send_result(32'hA5A55A5A, 4'b0001, crc_ref(32'hA5A55A5A, 4'b0001));
    idle(CPB);

    // Short low glitch: START sample sees 1, no output.
    sin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * CPB);
    chk("glitch_no_pulse", 64'(q.size()), 64'd0);
    send_result(32'hCAFEF00D, 4'b1100, crc_ref(32'hCAFEF00D, 4'b1100));

    // Sequencing violations.
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b0, 8'h02, 1'b1);
    q.push_back(mk(3));
    send_frame(1'b1, 8'h00, 1'b1);
    for (int b = 0; b < 4; b++) send_frame(1'b0, 8'(b), 1'b1);
    q.push_back(mk(3));
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h11, 1'b1);
    q.push_back(mk(3));
    send_frame(1'b1, 8'h81, 1'b1);
    idle(CPB);

    // Reset mid-payload after a partial packet.
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    sin = 1'b0;
    repeat (2 * CPB + 3 * CPB + 4) @(posedge clk);
    #1;
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_data_out", 64'(data_out), 64'd0);
    rst = 1'b0;
    idle(2 * CPB);
    send_result(32'h0BADF00D, 4'b0101, crc_ref(32'h0BADF00D, 4'b0101));
    idle(2 * CPB);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
